// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce_sync front-end.
package debounce_pkg;

  // Two-bit FSM encoding; stable states carry the committed level in bit 1.
  typedef enum logic [1:0] {
    StStableLo = 2'd0,
    StChkHi    = 2'd1,
    StStableHi = 2'd2,
    StChkLo    = 2'd3
  } state_e;

  localparam int unsigned GLITCH_CNT_W = 8;

endpackage

// File: rtl/sync_chain.sv
// N-flop synchronizer for a single asynchronous level; no logic between stages.
module sync_chain #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages_q;

  // Plain shift register; stage 0 takes the raw input.
  always_ff @(posedge clk) begin
    if (rst) begin
      stages_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      stages_q <= {stages_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizer plus counter-based debounce FSM producing a clean level for edge_detect.
// Optional rejected-bounce counter enabled by defining DEBOUNCE_GLITCH_CNT_EN.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic        RST_VAL         = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_in,
  output logic                    a_clean,
  output logic                    busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam state_e RST_STATE = RST_VAL ? StStableHi : StStableLo;

  logic a_sync;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic clean_q, clean_d;
  logic busy_q;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (RST_VAL)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (a_in),
    .q  (a_sync)
  );

  // In a CHK state cnt_q < DEBOUNCE_CYCLES, so the increment cannot wrap.
  assign cnt_inc = cnt_q + CNT_ONE;

  // Next-state: qualify a candidate level for DEBOUNCE_CYCLES consecutive synced samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    unique case (state_q)
      StStableLo: begin
        if (a_sync) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = StStableHi;
            clean_d = 1'b1;
          end else begin
            state_d = StChkHi;
            cnt_d   = CNT_ONE;
          end
        end
      end
      StChkHi: begin
        if (!a_sync) begin
          state_d = StStableLo;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_d = StStableHi;
          clean_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StStableHi: begin
        if (!a_sync) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = StStableLo;
            clean_d = 1'b0;
          end else begin
            state_d = StChkLo;
            cnt_d   = CNT_ONE;
          end
        end
      end
      StChkLo: begin
        if (a_sync) begin
          state_d = StStableHi;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_d = StStableLo;
          clean_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      clean_q <= RST_VAL;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      busy_q  <= (state_d == StChkHi) || (state_d == StChkLo);
    end
  end

  assign a_clean = clean_q;
  assign busy    = busy_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic                    revert;
  logic [GLITCH_CNT_W-1:0] glitch_q;

  assign revert = ((state_q == StChkHi) && !a_sync) || ((state_q == StChkLo) && a_sync);

  // Saturating count of rejected candidates; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_q <= '0;
    end else if (revert && (glitch_q != '1)) begin
      glitch_q <= glitch_q + 1'b1;
    end
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync: directed scenarios plus randomized levels,
// all compared every cycle against a sample-window model of the debounce rules.
module tb_debounce_sync;

  localparam int unsigned SYNC_STAGES     = 2;
  localparam int unsigned DEBOUNCE_CYCLES = 4;
  localparam logic        RST_VAL         = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_in = 1'b0;
  logic a_clean;
  logic busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int vectors = 0;
  int errors = 0;
  int rises = 0;
  logic prev_clean = 1'b0;

  // Model: delay line of raw samples, window of recently observed synced samples.
  logic pipe[$];
  logic win[$];
  logic m_clean;
  logic m_busy;
  int   m_glitch;

  always #5 clk = ~clk;

  debounce_sync #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RST_VAL        (RST_VAL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a_in      (a_in),
    .a_clean   (a_clean),
    .busy      (busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Level follows the synced input once the last DEBOUNCE_CYCLES observed samples all
  // disagree with it; busy means the newest observation disagrees with the held level.
  task automatic model_step(input logic r, input logic a);
    logic obs;
    logic all_diff;
    logic was_busy;
    if (r) begin
      pipe = {};
      for (int i = 0; i < SYNC_STAGES; i++) pipe.push_back(RST_VAL);
      win      = {};
      m_clean  = RST_VAL;
      m_busy   = 1'b0;
      m_glitch = 0;
    end else begin
      obs = pipe[SYNC_STAGES-1];
      pipe.push_front(a);
      void'(pipe.pop_back());
      win.push_back(obs);
      if (win.size() > DEBOUNCE_CYCLES) void'(win.pop_front());
      all_diff = (win.size() == DEBOUNCE_CYCLES);
      foreach (win[i]) if (win[i] == m_clean) all_diff = 1'b0;
      was_busy = m_busy;
      if (all_diff) m_clean = obs;
      else if (was_busy && (obs == m_clean) && (m_glitch < 255)) m_glitch++;
      m_busy = (obs != m_clean);
    end
  endtask

  task automatic compare();
    check("a_clean", int'(a_clean), int'(m_clean));
    check("busy", int'(busy), int'(m_busy));
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("glitch_cnt", int'(glitch_cnt), m_glitch);
`endif
  endtask

  // One clock: drive, let the edge happen, advance model, compare 1 time unit later.
  task automatic step(input logic r, input logic a);
    rst  = r;
    a_in = a;
    @(posedge clk);
    model_step(r, a);
    #1;
    compare();
    if (a_clean === 1'b1 && prev_clean === 1'b0) rises++;
    prev_clean = a_clean;
  endtask

  initial begin
    int run;
    logic lvl;

    // Reset with a_in high: outputs held at reset values.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1);
      check("rst_clean", int'(a_clean), 0);
      check("rst_busy", int'(busy), 0);
    end
    rises = 0;

    // Rising transition: busy after edges 2..4, a_clean on edge 5.
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1);
      if (k == 1) check("rise_busy_e1", int'(busy), 0);
      if (k == 2) check("rise_busy_e2", int'(busy), 1);
      if (k == 4) begin
        check("rise_busy_e4", int'(busy), 1);
        check("rise_clean_e4", int'(a_clean), 0);
      end
      if (k == 5) begin
        check("rise_clean_e5", int'(a_clean), 1);
        check("rise_busy_e5", int'(busy), 0);
      end
    end
    check("rise_count", rises, 1);

    // Falling transition from stable high.
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0);
      if (k == 4) check("fall_clean_e4", int'(a_clean), 1);
      if (k == 5) check("fall_clean_e5", int'(a_clean), 0);
    end

    // Short pulse from stable low is rejected.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0);
    check("pulse_clean", int'(a_clean), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("pulse_glitch", int'(glitch_cnt), 1);
`endif

    // Back to high, then a bouncy fall 1,0,1,0,0,0,0,0.
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1);
    check("rehigh_clean", int'(a_clean), 1);
    begin
      logic [7:0] bounce;
      bounce = 8'b1010_0000;
      for (int k = 0; k < 8; k++) step(1'b0, bounce[7-k]);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0);
    check("bounce_clean", int'(a_clean), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("bounce_glitch", int'(glitch_cnt), 2);
`endif

    // Reset in the middle of qualification, then a clean rise afterwards.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("midrst_clean", int'(a_clean), 0);
    check("midrst_busy", int'(busy), 0);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b1);
      if (k == 4) check("postrst_clean_e4", int'(a_clean), 0);
      if (k == 5) check("postrst_clean_e5", int'(a_clean), 1);
    end

    // Many 2-cycle low dips from stable high: a_clean holds, glitch count saturates.
    for (int p = 0; p < 300; p++) begin
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
    end
    check("sat_clean", int'(a_clean), 1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("sat_glitch", int'(glitch_cnt), 255);
`endif

    // Randomized runs of random length with occasional reset.
    lvl = 1'b0;
    for (int n = 0; n < 600; n++) begin
      run = $urandom_range(1, 7);
      lvl = ~lvl;
      for (int k = 0; k < run; k++) begin
        step(($urandom_range(0, 63) == 0), lvl);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
